imsic_msi_receiver: RTL and testbench



---
 rtl/imsic_msi_receiver.sv | 166 ++++++++++++++++
 tb/tb_imsic_msi_receiver.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imsic_msi_receiver.sv
// AXI4 write-only MSI endpoint: decodes writes into (hart, identity) set-pending requests queued in a FIFO.
// Optional macro IMSIC_SETEIPNUM_BE_EN also accepts big-endian writes at page offset 0x004.
module imsic_msi_receiver #(
    parameter int                 NrHarts    = 4,
    parameter int                 NrSources  = 64,
    parameter int                 AddrW      = 32,
    parameter int                 IdW        = 4,
    parameter logic [AddrW-1:0]   BaseAddr   = 'h2400_0000,
    parameter logic [AddrW-1:0]   HartStride = 'h1000,
    parameter int                 FifoDepth  = 4,
    localparam int                HartW      = (NrHarts > 1) ? $clog2(NrHarts) : 1,
    localparam int                IdentW     = $clog2(NrSources)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_awvalid,
    output logic              o_awready,
    input  logic [AddrW-1:0]  i_awaddr,
    input  logic [IdW-1:0]    i_awid,
    input  logic [7:0]        i_awlen,
    input  logic              i_wvalid,
    output logic              o_wready,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_wstrb,
    input  logic              i_wlast,
    output logic              o_bvalid,
    input  logic              i_bready,
    output logic [IdW-1:0]    o_bid,
    output logic [1:0]        o_bresp,
    output logic              o_setip_valid,
    input  logic              i_setip_ready,
    output logic [HartW-1:0]  o_setip_hart,
    output logic [IdentW-1:0] o_setip_id
);
    localparam int PtrW      = $clog2(FifoDepth) + 1;
    localparam int StrideLog = $clog2(HartStride);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q;
    logic [AddrW-1:0] addr_q;
    logic [IdW-1:0]   bid_q;
    logic [7:0]       len_q;
    logic [7:0]       beat_q;
    logic [1:0]       bresp_q;
    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [HartW+IdentW-1:0] fifo_mem [FifoDepth];

    logic [AddrW-1:0] off;
    logic [AddrW-1:0] hart_full;
    logic [AddrW-1:0] page_off;
    logic             in_range;
    logic             target_ok;
    logic [31:0]      ident_data;
    logic             ident_ok;
    logic             w_hs;
    logic             last_beat;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [1:0]       resp;
    logic             unused_wlast;

    assign unused_wlast = i_wlast;

    assign off       = addr_q - BaseAddr;
    assign hart_full = off >> StrideLog;
    assign page_off  = off & (HartStride - AddrW'(1));
    assign in_range  = (addr_q >= BaseAddr) && (hart_full < AddrW'(NrHarts));

`ifdef IMSIC_SETEIPNUM_BE_EN
    always_comb begin
        target_ok  = 1'b0;
        ident_data = i_wdata;
        if (page_off == AddrW'(0)) begin
            target_ok = 1'b1;
        end else if (page_off == AddrW'(4)) begin
            target_ok  = 1'b1;
            ident_data = {i_wdata[7:0], i_wdata[15:8], i_wdata[23:16], i_wdata[31:24]};
        end
    end
`else
    assign target_ok  = (page_off == AddrW'(0));
    assign ident_data = i_wdata;
`endif

    assign ident_ok  = (ident_data != 32'd0) && (ident_data < 32'(NrSources));
    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) && (wptr_q[PtrW-2:0] == rptr_q[PtrW-2:0]);
    assign pop       = !empty && i_setip_ready;
    assign last_beat = (beat_q == len_q);

    // Awready is masked during reset so the port reads 0 until the first cycle after release.
    assign o_awready = (state_q == ST_IDLE) && !i_rst;
    // Wready sees only registered full, so a same-cycle pop never unblocks a beat.
    assign o_wready  = (state_q == ST_DATA) && !full;
    assign o_bvalid  = (state_q == ST_RESP);
    assign o_bid     = bid_q;
    assign o_bresp   = bresp_q;
    assign w_hs      = i_wvalid && o_wready;
    assign push      = w_hs && (len_q == 8'd0) && in_range && target_ok && (i_wstrb == 4'hF) && ident_ok;

    always_comb begin
        resp = 2'b00;
        if (!in_range) begin
            resp = 2'b11;
        end else if (len_q != 8'd0) begin
            resp = 2'b10;
        end
    end

    assign o_setip_valid = !empty;
    assign {o_setip_hart, o_setip_id} = empty ? '0 : fifo_mem[rptr_q[PtrW-2:0]];

    // NOTE: the FIFO storage is deliberately not reset; the empty flag masks stale contents on the outputs.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wptr_q[PtrW-2:0]] <= {hart_full[HartW-1:0], ident_data[IdentW-1:0]};
        end
    end

    // NOTE: all state here updates with <= so every read in this block sees the pre-edge value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            bid_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            bresp_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (i_awvalid) begin
                        addr_q  <= i_awaddr;
                        bid_q   <= i_awid;
                        len_q   <= i_awlen;
                        beat_q  <= '0;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        beat_q <= beat_q + 8'd1;
                        if (last_beat) begin
                            bresp_q <= resp;
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (i_bready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imsic_msi_receiver.sv
// Self-checking bench for imsic_msi_receiver: vector table plus FIFO, latency and reset sequences.
// Set-pending outputs are checked against a scoreboard queue filled as pushing beats are accepted.
module tb_imsic_msi_receiver;
    localparam logic [31:0] Base = 32'h2400_0000;
    localparam int          Lim  = 200;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_awvalid;
    logic        o_awready;
    logic [31:0] i_awaddr;
    logic [3:0]  i_awid;
    logic [7:0]  i_awlen;
    logic        i_wvalid;
    logic        o_wready;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;
    logic        i_wlast;
    logic        o_bvalid;
    logic        i_bready;
    logic [3:0]  o_bid;
    logic [1:0]  o_bresp;
    logic        o_setip_valid;
    logic        i_setip_ready;
    logic [1:0]  o_setip_hart;
    logic [5:0]  o_setip_id;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic        exp_push;
        logic [1:0]  exp_hart;
        logic [5:0]  exp_id;
    } vec_t;

    vec_t       vecs[13];
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         writes_done;

    imsic_msi_receiver dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr), .i_awid(i_awid), .i_awlen(i_awlen),
        .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast),
        .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bid(o_bid), .o_bresp(o_bresp),
        .o_setip_valid(o_setip_valid), .i_setip_ready(i_setip_ready),
        .o_setip_hart(o_setip_hart), .o_setip_id(o_setip_id)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every set-pending handshake must match the oldest expected entry.
    always @(negedge i_clk) begin
        if (!i_rst && o_setip_valid && i_setip_ready) begin
            if (exp_q.size() == 0) begin
                check("setip_spurious", 64'(o_setip_valid), 64'd0);
            end else begin
                check("setip_entry", {o_setip_hart, o_setip_id}, exp_q.pop_front());
            end
        end
    end

    // All tasks start and end one time unit after a rising edge.
    task automatic aw_phase(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        int n = 0;
        i_awvalid = 1'b1; i_awaddr = addr; i_awid = id; i_awlen = len;
        @(negedge i_clk);
        while (!o_awready && n < Lim) begin n++; @(negedge i_clk); end
        if (n >= Lim) check("aw_timeout", 64'(o_awready), 64'd1);
        @(posedge i_clk); #1;
        i_awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        i_wvalid = 1'b1; i_wdata = data; i_wstrb = strb;
        @(negedge i_clk);
        while (!o_wready && n < Lim) begin n++; @(negedge i_clk); end
        if (n >= Lim) check("w_timeout", 64'(o_wready), 64'd1);
        @(posedge i_clk); #1;
        i_wvalid = 1'b0;
    endtask

    task automatic b_phase(input logic [3:0] id, input logic [1:0] resp, input string name);
        int n = 0;
        i_bready = 1'b1;
        @(negedge i_clk);
        while (!o_bvalid && n < Lim) begin n++; @(negedge i_clk); end
        if (n >= Lim) check({name, "_b_timeout"}, 64'(o_bvalid), 64'd1);
        check({name, "_bid"}, 64'(o_bid), 64'(id));
        check({name, "_bresp"}, 64'(o_bresp), 64'(resp));
        @(posedge i_clk); #1;
        i_bready = 1'b0;
    endtask

    task automatic do_write(input vec_t v, input string name);
        aw_phase(v.addr, v.id, v.len);
        for (int b = 0; b <= int'(v.len); b++) begin
            w_beat(v.data, v.strb);
            if (b == int'(v.len) && v.exp_push) exp_q.push_back({v.exp_hart, v.exp_id});
        end
        b_phase(v.id, v.exp_resp, name);
    endtask

    task automatic simple_write(input logic [1:0] hart, input logic [5:0] id, input logic [3:0] bid);
        vec_t v;
        v = '{Base + {18'd0, hart, 12'd0}, bid, 8'd0, {26'd0, id}, 4'hF, 2'b00, 1'b1, hart, id};
        do_write(v, "simple");
    endtask

    task automatic drain();
        int n = 0;
        i_setip_ready = 1'b1;
        while (exp_q.size() != 0 && n < Lim) begin n++; @(negedge i_clk); end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        check("drain_valid_low", 64'(o_setip_valid), 64'd0);
        @(posedge i_clk); #1;
    endtask

    initial begin
        vecs[0]  = '{Base + 32'h1000, 4'h3, 8'd0, 32'd5,          4'hF, 2'b00, 1'b1, 2'd1, 6'd5};
        vecs[1]  = '{Base + 32'h4000, 4'h1, 8'd0, 32'd5,          4'hF, 2'b11, 1'b0, 2'd0, 6'd0};
        vecs[2]  = '{Base - 32'd4,    4'h2, 8'd0, 32'd5,          4'hF, 2'b11, 1'b0, 2'd0, 6'd0};
        vecs[3]  = '{Base,            4'h4, 8'd3, 32'd5,          4'hF, 2'b10, 1'b0, 2'd0, 6'd0};
        vecs[4]  = '{Base,            4'h5, 8'd0, 32'd0,          4'hF, 2'b00, 1'b0, 2'd0, 6'd0};
        vecs[5]  = '{Base,            4'h6, 8'd0, 32'd64,         4'hF, 2'b00, 1'b0, 2'd0, 6'd0};
        vecs[6]  = '{Base,            4'h7, 8'd0, 32'd5,          4'h3, 2'b00, 1'b0, 2'd0, 6'd0};
        vecs[7]  = '{Base + 32'h3000, 4'h8, 8'd0, 32'd63,         4'hF, 2'b00, 1'b1, 2'd3, 6'd63};
        vecs[8]  = '{Base + 32'h0008, 4'h9, 8'd0, 32'd9,          4'hF, 2'b00, 1'b0, 2'd0, 6'd0};
`ifdef IMSIC_SETEIPNUM_BE_EN
        vecs[9]  = '{Base + 32'h0004, 4'hA, 8'd0, 32'h0700_0000,  4'hF, 2'b00, 1'b1, 2'd0, 6'd7};
`else
        vecs[9]  = '{Base + 32'h0004, 4'hA, 8'd0, 32'h0700_0000,  4'hF, 2'b00, 1'b0, 2'd0, 6'd0};
`endif
        vecs[10] = '{Base + 32'h2000, 4'hF, 8'd0, 32'd1,          4'hF, 2'b00, 1'b1, 2'd2, 6'd1};
        vecs[11] = '{Base + 32'h2004, 4'hB, 8'd0, 32'd5,          4'hF, 2'b00, 1'b0, 2'd0, 6'd0};
        vecs[12] = '{Base + 32'h4000, 4'hC, 8'd2, 32'd5,          4'hF, 2'b11, 1'b0, 2'd0, 6'd0};

        i_rst = 1'b1; i_awvalid = 1'b0; i_awaddr = '0; i_awid = '0; i_awlen = '0;
        i_wvalid = 1'b0; i_wdata = '0; i_wstrb = '0; i_wlast = 1'b1; i_bready = 1'b0;
        i_setip_ready = 1'b1;

        // Reset state.
        @(posedge i_clk); #1;
        @(negedge i_clk);
        check("rst_awready", 64'(o_awready), 64'd0);
        check("rst_wready", 64'(o_wready), 64'd0);
        check("rst_bvalid", 64'(o_bvalid), 64'd0);
        check("rst_setip_valid", 64'(o_setip_valid), 64'd0);
        check("rst_payload", {o_bid, o_bresp, o_setip_hart, o_setip_id}, 64'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("post_rst_awready", 64'(o_awready), 64'd1);
        @(posedge i_clk); #1;

        for (int i = 0; i < 13; i++) do_write(vecs[i], $sformatf("vec%0d", i));
        drain();

        // Minimum-latency single-beat transaction.
        i_awvalid = 1'b1; i_awaddr = Base + 32'h2000; i_awid = 4'h6; i_awlen = 8'd0;
        @(negedge i_clk);
        check("lat_awready_n", 64'(o_awready), 64'd1);
        @(posedge i_clk); #1;
        i_awvalid = 1'b0; i_wvalid = 1'b1; i_wdata = 32'd10; i_wstrb = 4'hF;
        @(negedge i_clk);
        check("lat_wready_n1", 64'(o_wready), 64'd1);
        check("lat_bvalid_n1", 64'(o_bvalid), 64'd0);
        check("lat_awready_n1", 64'(o_awready), 64'd0);
        @(posedge i_clk); #1;
        i_wvalid = 1'b0; i_bready = 1'b1;
        exp_q.push_back({2'd2, 6'd10});
        @(negedge i_clk);
        check("lat_bvalid_n2", 64'(o_bvalid), 64'd1);
        check("lat_setip_n2", 64'(o_setip_valid), 64'd1);
        check("lat_bid_n2", 64'(o_bid), 64'h6);
        check("lat_bresp_n2", 64'(o_bresp), 64'd0);
        @(posedge i_clk); #1;
        i_bready = 1'b0;
        @(negedge i_clk);
        check("lat_awready_n3", 64'(o_awready), 64'd1);
        check("lat_bvalid_n3", 64'(o_bvalid), 64'd0);
        @(posedge i_clk); #1;
        drain();

        // FIFO full: four entries queue, the fifth beat stalls until a pop has completed.
        i_setip_ready = 1'b0;
        for (int i = 0; i < 4; i++) simple_write(2'(i), 6'(20 + i), 4'(i));
        aw_phase(Base, 4'h1, 8'd0);
        i_wvalid = 1'b1; i_wdata = 32'd30; i_wstrb = 4'hF;
        for (int i = 0; i < 2; i++) begin
            @(negedge i_clk);
            check("full_stall", 64'(o_wready), 64'd0);
            @(posedge i_clk); #1;
        end
        i_setip_ready = 1'b1;
        @(negedge i_clk);
        check("full_stall_during_pop", 64'(o_wready), 64'd0);
        @(posedge i_clk); #1;
        i_setip_ready = 1'b0;
        @(negedge i_clk);
        check("full_resume", 64'(o_wready), 64'd1);
        @(posedge i_clk); #1;
        i_wvalid = 1'b0;
        exp_q.push_back({2'd0, 6'd30});
        b_phase(4'h1, 2'b00, "full5");
        check("full_queued", 64'(exp_q.size()), 64'd4);
        drain();

        // Back-to-back writes with ready toggling; pointers wrap more than once.
        writes_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++) simple_write(2'(i % 4), 6'(i + 1), 4'(i));
                writes_done = 1'b1;
            end
            begin
                for (int n = 0; n < 2000 && !writes_done; n++) begin
                    @(posedge i_clk); #1;
                    i_setip_ready = ~i_setip_ready;
                end
            end
        join
        drain();

        // Reset in DATA with two entries queued.
        i_setip_ready = 1'b0;
        simple_write(2'd1, 6'd11, 4'h2);
        simple_write(2'd2, 6'd12, 4'h3);
        aw_phase(Base + 32'h3000, 4'h9, 8'd0);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        exp_q.delete();
        @(negedge i_clk);
        check("midrst_awready", 64'(o_awready), 64'd0);
        check("midrst_wready", 64'(o_wready), 64'd0);
        check("midrst_bvalid", 64'(o_bvalid), 64'd0);
        check("midrst_setip_valid", 64'(o_setip_valid), 64'd0);
        check("midrst_payload", {o_bid, o_bresp, o_setip_hart, o_setip_id}, 64'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        i_setip_ready = 1'b1;
        @(negedge i_clk);
        check("midrst_no_b", 64'(o_bvalid), 64'd0);
        check("midrst_awready_after", 64'(o_awready), 64'd1);
        check("midrst_fifo_empty", 64'(o_setip_valid), 64'd0);
        @(posedge i_clk); #1;
        do_write(vecs[0], "post_rst");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
